// File: rtl/pc_gen.sv
// Next-PC generator feeding the fetch stage: boot, sequential advance, redirect,
// replay on decode back-pressure, halt and fetch-address fault detection.
module pc_gen #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 16384
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_req_i,
    input  logic        id_ready_i,
    output logic [31:0] next_pc_o,
    output logic        id_valid_o,
    output logic        halted_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o
);

    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);
    localparam logic [31:0] LAST_PC    = IMEM_BYTES - 32'd4;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_MISALGN = 2'b01;
    localparam logic [1:0] CAUSE_RANGE   = 2'b10;
    localparam logic [1:0] CAUSE_OVERRUN = 2'b11;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic [31:0] pres_pc_q;
    logic        id_valid_q, id_valid_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;

    logic redir_misaligned;
    logic redir_out_of_range;
    logic stall;

    assign redir_misaligned   = redirect_pc_i[1:0] != 2'b00;
    assign redir_out_of_range = redirect_pc_i >= IMEM_BYTES;
    assign stall              = id_valid_q && !id_ready_i;

    always_comb begin
        state_d    = state_q;
        next_pc_d  = next_pc_q;
        id_valid_d = 1'b0;
        halted_d   = halted_q;
        fault_d    = fault_q;
        cause_d    = cause_q;
        unique case (state_q)
            S_BOOT: begin
                // Fetch latches RESET_PC at this edge, so the stream continues one word on.
                state_d    = S_RUN;
                next_pc_d  = RESET_PC + 32'd4;
                id_valid_d = 1'b1;
            end
            S_RUN: begin
                if (halt_req_i) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else if (redirect_valid_i && redir_misaligned) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    cause_d = CAUSE_MISALGN;
                end else if (redirect_valid_i && redir_out_of_range) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    cause_d = CAUSE_RANGE;
                end else if (redirect_valid_i) begin
                    // Word fetched at this edge is wrong-path, hence the single bubble.
                    next_pc_d = redirect_pc_i;
                end else if (stall) begin
                    next_pc_d = pres_pc_q;
                end else if (next_pc_q == LAST_PC) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    cause_d = CAUSE_OVERRUN;
                end else begin
                    next_pc_d  = next_pc_q + 32'd4;
                    id_valid_d = 1'b1;
                end
            end
            S_HALT, S_FAULT: begin
                id_valid_d = 1'b0;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_BOOT;
            next_pc_q  <= RESET_PC;
            pres_pc_q  <= RESET_PC;
            id_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
            cause_q    <= CAUSE_NONE;
        end else begin
            state_q    <= state_d;
            next_pc_q  <= next_pc_d;
            pres_pc_q  <= next_pc_q;
            id_valid_q <= id_valid_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
            cause_q    <= cause_d;
        end
    end

    assign next_pc_o     = next_pc_q;
    assign id_valid_o    = id_valid_q;
    assign halted_o      = halted_q;
    assign fault_o       = fault_q;
    assign fault_cause_o = cause_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus randomized traffic, all checked
// against a cycle model of the fetch/PC behaviour kept here.
module tb_pc_gen;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] BYTES  = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        reset, redirect_valid, halt_req, id_ready;
    logic [31:0] redirect_pc;
    logic [31:0] next_pc;
    logic        id_valid, halted, fault;
    logic [1:0]  fault_cause;

    always #5 clk = ~clk;

    pc_gen #(.RESET_PC(RST_PC), .IMEM_WORDS(16384)) dut (
        .clk_i(clk), .reset_i(reset), .redirect_valid_i(redirect_valid),
        .redirect_pc_i(redirect_pc), .halt_req_i(halt_req), .id_ready_i(id_ready),
        .next_pc_o(next_pc), .id_valid_o(id_valid), .halted_o(halted),
        .fault_o(fault), .fault_cause_o(fault_cause)
    );

    int n_vec = 0;
    int n_err = 0;
    int cons8 = 0;

    // Model: "mode" is what the machine is doing, m_pc1 is what fetch holds.
    string       m_mode;
    logic [31:0] m_nx, m_pc1;
    logic        m_v, m_h, m_f;
    logic [1:0]  m_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [31:0] held;
        held  = m_pc1;
        m_pc1 = m_nx;
        if (reset) begin
            m_mode = "boot"; m_nx = RST_PC; m_pc1 = RST_PC;
            m_v = 0; m_h = 0; m_f = 0; m_c = 2'd0;
        end else if (m_mode == "boot") begin
            m_mode = "run"; m_nx = RST_PC + 4; m_v = 1;
        end else if (m_mode == "run") begin
            m_v = 0;
            if (halt_req) begin
                m_mode = "halt"; m_h = 1;
            end else if (redirect_valid && (redirect_pc % 4 != 0)) begin
                m_mode = "fault"; m_f = 1; m_c = 2'd1;
            end else if (redirect_valid && redirect_pc >= BYTES) begin
                m_mode = "fault"; m_f = 1; m_c = 2'd2;
            end else if (redirect_valid) begin
                m_nx = redirect_pc;
            end else if (m_v_prev_valid(held) && !id_ready) begin
                m_nx = held;
            end else if (m_nx + 4 == BYTES) begin
                m_mode = "fault"; m_f = 1; m_c = 2'd3;
            end else begin
                m_nx = m_nx + 4; m_v = 1;
            end
        end else begin
            m_v = 0;
        end
    endtask

    // Validity of what fetch held before this edge (captured before model_edge clears it).
    logic prev_v;
    function automatic logic m_v_prev_valid(input logic [31:0] unused_pc);
        return prev_v && (unused_pc === unused_pc);
    endfunction

    task automatic tick();
        if (id_valid && id_ready && m_pc1 == 32'h8) cons8++;
        prev_v = m_v;
        @(posedge clk);
        model_edge();
        #1;
        chk("model_next_pc", next_pc, m_nx);
        chk("model_id_valid", {31'd0, id_valid}, {31'd0, m_v});
        chk("model_halted", {31'd0, halted}, {31'd0, m_h});
        chk("model_fault", {31'd0, fault}, {31'd0, m_f});
        chk("model_cause", {30'd0, fault_cause}, {30'd0, m_c});
    endtask

    task automatic rand_ins();
        halt_req       = ($urandom % 3) == 0;
        redirect_valid = ($urandom % 2) == 0;
        redirect_pc    = $urandom;
        id_ready       = ($urandom % 2) == 0;
    endtask

    initial begin
        m_mode = "boot"; m_nx = RST_PC; m_pc1 = RST_PC;
        m_v = 0; m_h = 0; m_f = 0; m_c = 0; prev_v = 0;
        reset = 1; redirect_valid = 0; redirect_pc = 0; halt_req = 0; id_ready = 1;

        // 1: boot and sequential advance
        tick(); tick();
        chk("t1_boot_valid", {31'd0, id_valid}, 32'd0);
        chk("t1_boot_pc", next_pc, 32'h0);
        reset = 0;
        tick(); chk("t1_pc4", next_pc, 32'h4); chk("t1_v", {31'd0, id_valid}, 32'd1);
        tick(); chk("t1_pc8", next_pc, 32'h8);
        tick(); chk("t1_pcC", next_pc, 32'hC);
        tick(); chk("t1_pc10", next_pc, 32'h10);

        // 2: redirect costs one bubble
        redirect_valid = 1; redirect_pc = 32'h100;
        tick(); chk("t2_redir_pc", next_pc, 32'h100); chk("t2_bubble", {31'd0, id_valid}, 32'd0);
        redirect_valid = 0;
        tick(); chk("t2_tgt_next", next_pc, 32'h104); chk("t2_tgt_v", {31'd0, id_valid}, 32'd1);

        // 3: single stall replays pc 0x8, consumed exactly once
        reset = 1; tick(); reset = 0;
        cons8 = 0;
        tick(); tick(); tick();
        chk("t3_pre_next", next_pc, 32'hC);
        id_ready = 0;
        tick(); chk("t3_replay_pc", next_pc, 32'h8); chk("t3_replay_v", {31'd0, id_valid}, 32'd0);
        id_ready = 1;
        tick(); chk("t3_back_next", next_pc, 32'hC); chk("t3_back_v", {31'd0, id_valid}, 32'd1);
        tick(); tick();
        chk("t3_consumed_once", cons8, 32'd1);

        // 4: misaligned and out-of-range redirects fault and stick
        redirect_valid = 1; redirect_pc = 32'h102;
        tick(); chk("t4_mis_fault", {31'd0, fault}, 32'd1); chk("t4_mis_cause", {30'd0, fault_cause}, 32'd1);
        for (int i = 0; i < 20; i++) begin rand_ins(); tick(); end
        chk("t4_mis_hold", {30'd0, fault_cause}, 32'd1); chk("t4_mis_v", {31'd0, id_valid}, 32'd0);
        halt_req = 0; redirect_valid = 0; id_ready = 1;
        reset = 1; tick(); reset = 0; tick();
        redirect_valid = 1; redirect_pc = 32'h0001_0000;
        tick(); chk("t4_rng_fault", {31'd0, fault}, 32'd1); chk("t4_rng_cause", {30'd0, fault_cause}, 32'd2);
        for (int i = 0; i < 20; i++) begin rand_ins(); tick(); end
        chk("t4_rng_hold", {30'd0, fault_cause}, 32'd2); chk("t4_rng_v", {31'd0, id_valid}, 32'd0);

        // 5: halt beats redirect; reset leaves HALT
        halt_req = 0; redirect_valid = 0; id_ready = 1;
        reset = 1; tick(); reset = 0; tick(); tick();
        halt_req = 1; redirect_valid = 1; redirect_pc = 32'h200;
        tick(); chk("t5_halted", {31'd0, halted}, 32'd1); chk("t5_pc_held", next_pc, 32'h8);
        halt_req = 0; redirect_valid = 0;
        tick(); tick(); chk("t5_frozen", next_pc, 32'h8);
        reset = 1;
        tick(); chk("t5_rst_halted", {31'd0, halted}, 32'd0); chk("t5_rst_pc", next_pc, RST_PC);

        // 6: sequential overrun at top of memory, no wrap
        reset = 0; tick();
        redirect_valid = 1; redirect_pc = 32'hFFF8;
        tick(); chk("t6_redir", next_pc, 32'hFFF8);
        redirect_valid = 0;
        tick(); chk("t6_last", next_pc, 32'hFFFC); chk("t6_v", {31'd0, id_valid}, 32'd1);
        tick(); chk("t6_fault", {31'd0, fault}, 32'd1); chk("t6_cause", {30'd0, fault_cause}, 32'd3);
        for (int i = 0; i < 5; i++) tick();
        chk("t6_nowrap", next_pc, 32'hFFFC);

        // Randomized traffic
        reset = 1; tick(); reset = 0;
        for (int i = 0; i < 1500; i++) begin
            int r;
            reset    = ((m_mode == "halt" || m_mode == "fault") && ($urandom % 4 == 0)) || ($urandom % 300 == 0);
            halt_req = ($urandom % 120) == 0;
            id_ready = ($urandom % 3) != 0;
            redirect_valid = ($urandom % 8) == 0;
            r = int'($urandom % 16);
            if (r == 0)      redirect_pc = {$urandom % 32'h4000, 2'b00} | 32'(1 + $urandom % 3);
            else if (r == 1) redirect_pc = BYTES + ($urandom % 32'h100);
            else if (r == 2) redirect_pc = BYTES - 32'(4 * (1 + $urandom % 3));
            else             redirect_pc = {20'd0, $urandom % 32'h400, 2'b00};
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
